// File: rtl/rs_fp.sv
// rs_fp: two-entry floating-point reservation station.
// Entries are filled from dispatch (entry 0 preferred), woken by the
// writeback broadcast, and emptied by the execution unit's issue pulses
// or by flush. Optional performance counters are enabled with the
// RS_FP_PERF_EN macro.
module rs_fp (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         disp_valid,
  input  logic [4:0]   disp_aluop,
  input  logic [4:0]   disp_rd,
  input  logic         disp_fpregwrite,
  input  logic [3:0]   disp_rob_num,
  input  logic         disp_rs1_rdy,
  input  logic [31:0]  disp_rs1_val,
  input  logic [3:0]   disp_rs1_tag,
  input  logic         disp_rs2_rdy,
  input  logic [31:0]  disp_rs2_val,
  input  logic [3:0]   disp_rs2_tag,
  output logic         disp_ready,
  input  logic         wb_valid,
  input  logic [3:0]   wb_tag,
  input  logic [31:0]  wb_data,
  input  logic         flush,
  output logic [113:0] rs_fp_0,
  output logic [113:0] rs_fp_1,
  output logic [3:0]   rs_fp_0_entry_num,
  output logic [3:0]   rs_fp_1_entry_num,
  output logic         selector,
  input  logic         fp_0_issue,
  input  logic         fp_1_issue
`ifdef RS_FP_PERF_EN
  ,
  output logic [15:0]  perf_issue_cnt,
  output logic [15:0]  perf_full_cnt
`endif
);

  // Field order matches bits [88:0] of the issue-side entry word.
  typedef struct packed {
    logic [3:0]  rob;
    logic [3:0]  rs2_tag;
    logic [4:0]  aluop;
    logic [3:0]  rs1_tag;
    logic        fpregwrite;
    logic [31:0] rs2_val;
    logic        rs2_rdy;
    logic [31:0] rs1_val;
    logic        rs1_rdy;
    logic [4:0]  rd;
  } entry_t;

  entry_t     ent [2];
  logic [1:0] valid;
  logic [1:0] issue;
  logic       disp_fire;
  logic       disp_sel;
  entry_t     disp_ent;

  assign issue      = {fp_1_issue, fp_0_issue};
  assign disp_ready = ~(valid[0] & valid[1]);
  assign disp_fire  = disp_valid & disp_ready;
  assign disp_sel   = valid[0];

  // Build the entry being dispatched, folding in a same-cycle wakeup.
  always_comb begin
    disp_ent            = '0;
    disp_ent.rob        = disp_rob_num;
    disp_ent.rs2_tag    = disp_rs2_tag;
    disp_ent.aluop      = disp_aluop;
    disp_ent.rs1_tag    = disp_rs1_tag;
    disp_ent.fpregwrite = disp_fpregwrite;
    disp_ent.rd         = disp_rd;
    disp_ent.rs1_rdy    = disp_rs1_rdy;
    disp_ent.rs1_val    = disp_rs1_val;
    disp_ent.rs2_rdy    = disp_rs2_rdy;
    disp_ent.rs2_val    = disp_rs2_val;
    if (wb_valid && !disp_rs1_rdy && (disp_rs1_tag == wb_tag)) begin
      disp_ent.rs1_rdy = 1'b1;
      disp_ent.rs1_val = wb_data;
    end
    if (wb_valid && !disp_rs2_rdy && (disp_rs2_tag == wb_tag)) begin
      disp_ent.rs2_rdy = 1'b1;
      disp_ent.rs2_val = wb_data;
    end
  end

  // Entry state: flush beats everything, issue beats wakeup, and only a free entry takes a dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      ent[0]   <= '0;
      ent[1]   <= '0;
      selector <= 1'b0;
    end else if (flush) begin
      valid    <= '0;
      ent[0]   <= '0;
      ent[1]   <= '0;
      selector <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (valid[i]) begin
          if (issue[i]) begin
            valid[i] <= 1'b0;
            ent[i]   <= '0;
          end else begin
            if (wb_valid && !ent[i].rs1_rdy && (ent[i].rs1_tag == wb_tag)) begin
              ent[i].rs1_rdy <= 1'b1;
              ent[i].rs1_val <= wb_data;
            end
            if (wb_valid && !ent[i].rs2_rdy && (ent[i].rs2_tag == wb_tag)) begin
              ent[i].rs2_rdy <= 1'b1;
              ent[i].rs2_val <= wb_data;
            end
          end
        end else if (disp_fire && (disp_sel == 1'(i))) begin
          valid[i] <= 1'b1;
          ent[i]   <= disp_ent;
        end
      end
      if (disp_fire) begin
        selector <= disp_sel;
      end
    end
  end

  // Issue-side views straight from the registers; invalid entries read as zero.
  always_comb begin
    rs_fp_0           = valid[0] ? {24'b0, 1'b1, ent[0]} : '0;
    rs_fp_1           = valid[1] ? {24'b0, 1'b1, ent[1]} : '0;
    rs_fp_0_entry_num = valid[0] ? ent[0].rob : '0;
    rs_fp_1_entry_num = valid[1] ? ent[1].rob : '0;
  end

`ifdef RS_FP_PERF_EN
  logic [1:0] issue_hit;
  assign issue_hit = issue & valid;

  // Counters survive flush; only reset clears them. Both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      perf_issue_cnt <= perf_issue_cnt + 16'(issue_hit[0]) + 16'(issue_hit[1]);
      perf_full_cnt  <= perf_full_cnt + 16'(disp_valid & ~disp_ready);
    end
  end
`endif

endmodule

// File: tb/tb_rs_fp.sv
// tb_rs_fp: directed-vector bench for rs_fp. The driver pushes the
// hand-computed expected state after each step into a queue; a monitor
// on the falling clock edge pops and compares against the DUT outputs.
// Performance counters are checked when RS_FP_PERF_EN is defined.
module tb_rs_fp;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         disp_valid;
  logic [4:0]   disp_aluop;
  logic [4:0]   disp_rd;
  logic         disp_fpregwrite;
  logic [3:0]   disp_rob_num;
  logic         disp_rs1_rdy;
  logic [31:0]  disp_rs1_val;
  logic [3:0]   disp_rs1_tag;
  logic         disp_rs2_rdy;
  logic [31:0]  disp_rs2_val;
  logic [3:0]   disp_rs2_tag;
  logic         disp_ready;
  logic         wb_valid;
  logic [3:0]   wb_tag;
  logic [31:0]  wb_data;
  logic         flush;
  logic [113:0] rs_fp_0;
  logic [113:0] rs_fp_1;
  logic [3:0]   rs_fp_0_entry_num;
  logic [3:0]   rs_fp_1_entry_num;
  logic         selector;
  logic         fp_0_issue;
  logic         fp_1_issue;
`ifdef RS_FP_PERF_EN
  logic [15:0]  perf_issue_cnt;
  logic [15:0]  perf_full_cnt;
`endif

  rs_fp dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_aluop(disp_aluop), .disp_rd(disp_rd),
    .disp_fpregwrite(disp_fpregwrite), .disp_rob_num(disp_rob_num),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val), .disp_rs2_tag(disp_rs2_tag),
    .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .flush(flush),
    .rs_fp_0(rs_fp_0), .rs_fp_1(rs_fp_1),
    .rs_fp_0_entry_num(rs_fp_0_entry_num), .rs_fp_1_entry_num(rs_fp_1_entry_num),
    .selector(selector),
    .fp_0_issue(fp_0_issue), .fp_1_issue(fp_1_issue)
`ifdef RS_FP_PERF_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_full_cnt(perf_full_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [113:0] e0;
    logic [113:0] e1;
    logic [3:0]   n0;
    logic [3:0]   n1;
    logic         sel;
    logic         rdy;
    logic [15:0]  pic;
    logic [15:0]  pfc;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];

  int total = 0;
  int bad   = 0;

  logic [113:0] x0, x1;
  logic         xsel;
  logic [15:0]  xpic, xpfc;

  function automatic logic [113:0] mk_entry(
    input logic [3:0] rob, input logic [4:0] rd, input logic [4:0] aluop, input logic fpw,
    input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
    input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag);
    return {24'b0, 1'b1, rob, r2tag, aluop, r1tag, fpw, r2val, r2rdy, r1val, r1rdy, rd};
  endfunction

  task automatic check_output(input string name, input string field,
                              input logic [113:0] act, input logic [113:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s.%s: got %h want %h", name, field, act, want);
    end
  endtask

  task automatic idle_inputs();
    disp_valid = 0; disp_aluop = 0; disp_rd = 0; disp_fpregwrite = 0; disp_rob_num = 0;
    disp_rs1_rdy = 0; disp_rs1_val = 0; disp_rs1_tag = 0;
    disp_rs2_rdy = 0; disp_rs2_val = 0; disp_rs2_tag = 0;
    wb_valid = 0; wb_tag = 0; wb_data = 0;
    flush = 0; fp_0_issue = 0; fp_1_issue = 0;
  endtask

  task automatic set_disp(
    input logic [3:0] rob, input logic [4:0] rd, input logic [4:0] aluop, input logic fpw,
    input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
    input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag);
    disp_valid = 1; disp_rob_num = rob; disp_rd = rd; disp_aluop = aluop; disp_fpregwrite = fpw;
    disp_rs1_rdy = r1rdy; disp_rs1_val = r1val; disp_rs1_tag = r1tag;
    disp_rs2_rdy = r2rdy; disp_rs2_val = r2val; disp_rs2_tag = r2tag;
  endtask

  task automatic set_wb(input logic [3:0] tag, input logic [31:0] data);
    wb_valid = 1; wb_tag = tag; wb_data = data;
  endtask

  task automatic push_exp(input string name);
    exp_t r;
    r.e0  = x0;
    r.e1  = x1;
    r.n0  = x0[88:85];
    r.n1  = x1[88:85];
    r.sel = xsel;
    r.rdy = !(x0[89] && x1[89]);
    r.pic = xpic;
    r.pfc = xpfc;
    exp_q.push_back(r);
    name_q.push_back(name);
  endtask

  // One clock edge with the currently driven inputs, then expect the post-edge state.
  task automatic apply_stimulus(input string name);
    @(posedge clk);
    #1;
    push_exp(name);
    idle_inputs();
  endtask

  // Monitor: compare every queued expectation against the DUT on the falling edge.
  always @(negedge clk) begin
    exp_t  r;
    string nm;
    while (exp_q.size() > 0) begin
      r  = exp_q.pop_front();
      nm = name_q.pop_front();
      check_output(nm, "rs_fp_0", rs_fp_0, r.e0);
      check_output(nm, "rs_fp_1", rs_fp_1, r.e1);
      check_output(nm, "entry_num_0", 114'(rs_fp_0_entry_num), 114'(r.n0));
      check_output(nm, "entry_num_1", 114'(rs_fp_1_entry_num), 114'(r.n1));
      check_output(nm, "selector", 114'(selector), 114'(r.sel));
      check_output(nm, "disp_ready", 114'(disp_ready), 114'(r.rdy));
`ifdef RS_FP_PERF_EN
      check_output(nm, "perf_issue_cnt", 114'(perf_issue_cnt), 114'(r.pic));
      check_output(nm, "perf_full_cnt", 114'(perf_full_cnt), 114'(r.pfc));
`endif
    end
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    x0 = '0; x1 = '0; xsel = 0; xpic = 0; xpfc = 0;
    rst_n = 0;
    idle_inputs();
    #1;
    push_exp("reset_state");
    @(negedge clk);
    #1;
    rst_n = 1;
    apply_stimulus("after_release");

    // Empty station: first dispatch lands in entry 0.
    set_disp(4'd3, 5'd1, 5'd2, 1'b1, 1'b1, 32'h11111111, 4'd0, 1'b1, 32'h22222222, 4'd0);
    x0 = mk_entry(4'd3, 5'd1, 5'd2, 1'b1, 1'b1, 32'h11111111, 4'd0, 1'b1, 32'h22222222, 4'd0);
    apply_stimulus("dispatch_empty");

    // Second dispatch fills entry 1.
    set_disp(4'd5, 5'd2, 5'd4, 1'b0, 1'b1, 32'hAAAA0000, 4'd1, 1'b0, 32'h0000DEAD, 4'd9);
    x1 = mk_entry(4'd5, 5'd2, 5'd4, 1'b0, 1'b1, 32'hAAAA0000, 4'd1, 1'b0, 32'h0000DEAD, 4'd9);
    xsel = 1;
    apply_stimulus("dispatch_fill");

    // Full station ignores a third dispatch.
    set_disp(4'd6, 5'd9, 5'd9, 1'b1, 1'b1, 32'h99999999, 4'd0, 1'b1, 32'h88888888, 4'd0);
    xpfc = 1;
    apply_stimulus("dispatch_when_full");

    // Wakeup of entry 1 rs2.
    set_wb(4'd9, 32'h3F800000);
    x1 = mk_entry(4'd5, 5'd2, 5'd4, 1'b0, 1'b1, 32'hAAAA0000, 4'd1, 1'b1, 32'h3F800000, 4'd9);
    apply_stimulus("wakeup_rs2");

    // Broadcast matching only already-ready tags changes nothing.
    set_wb(4'd0, 32'h00000055);
    apply_stimulus("wakeup_ready_ignored");

    // Issue entry 0 with a dispatch attempt: still not ready this cycle.
    fp_0_issue = 1;
    set_disp(4'd7, 5'd9, 5'd9, 1'b0, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
    push_exp("issue_same_cycle");
    x0 = '0; xpic = 1; xpfc = 2;
    apply_stimulus("issue_entry0");

    // Dispatch with same-cycle bypass on both operands, lands in entry 0.
    set_disp(4'd8, 5'd3, 5'd5, 1'b1, 1'b0, 32'h0, 4'd2, 1'b0, 32'h0, 4'd2);
    set_wb(4'd2, 32'h40000000);
    x0 = mk_entry(4'd8, 5'd3, 5'd5, 1'b1, 1'b1, 32'h40000000, 4'd2, 1'b1, 32'h40000000, 4'd2);
    xsel = 0;
    apply_stimulus("dispatch_bypass");

    fp_1_issue = 1;
    x1 = '0; xpic = 2;
    apply_stimulus("issue_entry1");

    set_disp(4'd10, 5'd4, 5'd6, 1'b0, 1'b0, 32'h0, 4'd7, 1'b0, 32'h0, 4'd7);
    x1 = mk_entry(4'd10, 5'd4, 5'd6, 1'b0, 1'b0, 32'h0, 4'd7, 1'b0, 32'h0, 4'd7);
    xsel = 1;
    apply_stimulus("dispatch_entry1_waiting");

    // One broadcast wakes both operands.
    set_wb(4'd7, 32'h3F800000);
    x1 = mk_entry(4'd10, 5'd4, 5'd6, 1'b0, 1'b1, 32'h3F800000, 4'd7, 1'b1, 32'h3F800000, 4'd7);
    apply_stimulus("wakeup_both_operands");

    fp_0_issue = 1; fp_1_issue = 1;
    x0 = '0; x1 = '0; xpic = 4;
    apply_stimulus("double_issue");

    set_disp(4'd12, 5'd5, 5'd1, 1'b0, 1'b0, 32'h0, 4'd3, 1'b1, 32'h12345678, 4'd0);
    x0 = mk_entry(4'd12, 5'd5, 5'd1, 1'b0, 1'b0, 32'h0, 4'd3, 1'b1, 32'h12345678, 4'd0);
    xsel = 0;
    apply_stimulus("dispatch_e0_wait3");

    set_disp(4'd13, 5'd6, 5'd3, 1'b1, 1'b1, 32'h87654321, 4'd0, 1'b0, 32'h0, 4'd3);
    x1 = mk_entry(4'd13, 5'd6, 5'd3, 1'b1, 1'b1, 32'h87654321, 4'd0, 1'b0, 32'h0, 4'd3);
    xsel = 1;
    apply_stimulus("dispatch_e1_wait3");

    // Issue beats wakeup on entry 0; entry 1 still wakes.
    set_wb(4'd3, 32'hCAFEF00D);
    fp_0_issue = 1;
    x0 = '0;
    x1 = mk_entry(4'd13, 5'd6, 5'd3, 1'b1, 1'b1, 32'h87654321, 4'd0, 1'b1, 32'hCAFEF00D, 4'd3);
    xpic = 5;
    apply_stimulus("issue_beats_wakeup");

    fp_0_issue = 1;
    apply_stimulus("issue_invalid_ignored");

    // Flush overrides dispatch and wakeup.
    flush = 1;
    set_disp(4'd14, 5'd7, 5'd7, 1'b1, 1'b0, 32'h0, 4'd3, 1'b1, 32'h5, 4'd0);
    set_wb(4'd3, 32'h11112222);
    x0 = '0; x1 = '0; xsel = 0;
    apply_stimulus("flush");

    set_disp(4'd1, 5'd7, 5'd8, 1'b1, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
    x0 = mk_entry(4'd1, 5'd7, 5'd8, 1'b1, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
    apply_stimulus("dispatch_before_reset");

    // Mid-operation reset drops everything, counters included.
    @(negedge clk);
    #1;
    rst_n = 0;
    x0 = '0; x1 = '0; xsel = 0; xpic = 0; xpfc = 0;
    push_exp("async_reset");
    @(negedge clk);
    #1;
    rst_n = 1;
    apply_stimulus("after_reset_release");

    set_disp(4'd2, 5'd1, 5'd1, 1'b0, 1'b1, 32'hABCD0001, 4'd0, 1'b1, 32'hABCD0002, 4'd0);
    x0 = mk_entry(4'd2, 5'd1, 5'd1, 1'b0, 1'b1, 32'hABCD0001, 4'd0, 1'b1, 32'hABCD0002, 4'd0);
    apply_stimulus("dispatch_after_reset");

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
